// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller for the dual-clock FIFO test memory.
// Turns a push handshake into RAM write-port signals, tracks occupancy
// against a synchronized Gray read pointer and exports its own Gray pointer.
// Optional feature macro: FIFO_WR_AFULL_EN adds the registered 'afull' output.

module fifo_wr_ctrl #(
  parameter int RAM_WW       = 18,
  parameter int RAM_WD       = 10,
  parameter int AFULL_THRESH = 1020
) (
  input  logic              wclk_int,
  input  logic              rst_int,
  input  logic              wr_en,
  input  logic [RAM_WW-1:0] wr_data,
  input  logic [RAM_WD:0]   rd_ptr_gray,
  output logic [RAM_WD-1:0] waddr,
  output logic [RAM_WW-1:0] data,
  output logic              we,
  output logic [RAM_WD:0]   wr_ptr_gray,
  output logic              full,
  output logic [RAM_WD:0]   wr_count,
  output logic              overflow
`ifdef FIFO_WR_AFULL_EN
  ,
  output logic              afull
`endif
);

  localparam int PW = RAM_WD + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {RAM_WD{1'b0}}};

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] rd_sync1;
  logic [PW-1:0] rd_sync2;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] wr_count_next;
  logic          accept;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Accept decision and next-state occupancy from the registered full flag
  always_comb begin
    accept        = wr_en && !full;
    wbin_next     = wbin + PW'(accept);
    rbin_s        = gray2bin(rd_sync2);
    wr_count_next = wbin_next - rbin_s;
  end

  // Two-stage synchronizer for the read pointer crossing from the read clock
  always_ff @(posedge wclk_int or negedge rst_int) begin
    if (!rst_int) begin
      rd_sync1 <= '0;
      rd_sync2 <= '0;
    end else begin
      rd_sync1 <= rd_ptr_gray;
      rd_sync2 <= rd_sync1;
    end
  end

  // Write pointer, RAM write port and the lagging Gray pointer export
  always_ff @(posedge wclk_int or negedge rst_int) begin
    if (!rst_int) begin
      wbin        <= '0;
      we          <= 1'b0;
      waddr       <= '0;
      data        <= '0;
      overflow    <= 1'b0;
      wr_ptr_gray <= '0;
    end else begin
      wbin        <= wbin_next;
      we          <= accept;
      overflow    <= wr_en && full;
      wr_ptr_gray <= bin2gray(wbin);
      if (accept) begin
        waddr <= wbin[RAM_WD-1:0];
        data  <= wr_data;
      end
    end
  end

  // Occupancy and full flag, computed from the post-push write pointer
  always_ff @(posedge wclk_int or negedge rst_int) begin
    if (!rst_int) begin
      wr_count <= '0;
      full     <= 1'b0;
    end else begin
      wr_count <= wr_count_next;
      full     <= (wr_count_next == DEPTH);
    end
  end

`ifdef FIFO_WR_AFULL_EN
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  // Almost-full flag, updated on the same edge as full
  always_ff @(posedge wclk_int or negedge rst_int) begin
    if (!rst_int) begin
      afull <= 1'b0;
    end else begin
      afull <= (wr_count_next >= AFULL_LVL);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed self-checking bench for fifo_wr_ctrl with a
// write scoreboard holding the expected {waddr, data} of every accepted push.
// Build with FIFO_WR_AFULL_EN defined to also exercise the afull output.

module tb_fifo_wr_ctrl;

  localparam int RAM_WW = 18;
  localparam int RAM_WD = 10;
  localparam int PW     = RAM_WD + 1;

  logic              wclk_int;
  logic              rst_int;
  logic              wr_en;
  logic [RAM_WW-1:0] wr_data;
  logic [PW-1:0]     rd_ptr_gray;
  logic [RAM_WD-1:0] waddr;
  logic [RAM_WW-1:0] data;
  logic              we;
  logic [PW-1:0]     wr_ptr_gray;
  logic              full;
  logic [PW-1:0]     wr_count;
  logic              overflow;
`ifdef FIFO_WR_AFULL_EN
  logic              afull;
`endif

  int checks = 0;
  int errors = 0;
  logic [RAM_WD+RAM_WW-1:0] sb[$];

  fifo_wr_ctrl #(
    .RAM_WW(RAM_WW),
    .RAM_WD(RAM_WD),
    .AFULL_THRESH(1020)
  ) dut (
    .wclk_int(wclk_int),
    .rst_int(rst_int),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_ptr_gray(rd_ptr_gray),
    .waddr(waddr),
    .data(data),
    .we(we),
    .wr_ptr_gray(wr_ptr_gray),
    .full(full),
    .wr_count(wr_count),
    .overflow(overflow)
`ifdef FIFO_WR_AFULL_EN
    ,
    .afull(afull)
`endif
  );

  initial wclk_int = 1'b0;
  always #5 wclk_int = ~wclk_int;

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of push request, clock it, then retire any RAM write
  task automatic applyStimulus(input logic en, input logic [RAM_WW-1:0] dat);
    logic [RAM_WD+RAM_WW-1:0] item;
    wr_en   = en;
    wr_data = dat;
    @(posedge wclk_int);
    #1;
    if (we === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("[TB] FAIL sb_underflow observed we=1 waddr=%0h expected no write", waddr);
      end
      if (sb.size() > 0) begin
        item = sb.pop_front();
        checkOutput("wr_addr", 32'(waddr), 32'(item[RAM_WD+RAM_WW-1:RAM_WW]));
        checkOutput("wr_data", 32'(data), 32'(item[RAM_WW-1:0]));
      end
    end
  endtask

  initial begin
    logic [PW-1:0]     mwbin;
    logic [PW-1:0]     prevg;
    logic [PW-1:0]     d1;
    logic [PW-1:0]     d2;
    logic [RAM_WD-1:0] prev_waddr;
    logic [RAM_WW-1:0] dat;
    int ptr_wraps;
    int addr_wraps;

    rst_int     = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    rd_ptr_gray = '0;
    repeat (3) @(posedge wclk_int);
    #1;
    checkOutput("rst_we", 32'(we), 0);
    checkOutput("rst_waddr", 32'(waddr), 0);
    checkOutput("rst_data", 32'(data), 0);
    checkOutput("rst_wptr", 32'(wr_ptr_gray), 0);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_count", 32'(wr_count), 0);
    checkOutput("rst_ovf", 32'(overflow), 0);
`ifdef FIFO_WR_AFULL_EN
    checkOutput("rst_afull", 32'(afull), 0);
`endif
    rst_int = 1'b1;

    // Fill all 1024 slots with data = index
    for (int i = 0; i < 1024; i++) begin
      sb.push_back({RAM_WD'(i), RAM_WW'(i)});
      applyStimulus(1'b1, RAM_WW'(i));
      checkOutput("fill_we", 32'(we), 1);
      checkOutput("fill_count", 32'(wr_count), 32'(i + 1));
      checkOutput("fill_full", 32'(full), (i == 1023) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, '0);
    checkOutput("fill_we_off", 32'(we), 0);
    checkOutput("fill_wptr", 32'(wr_ptr_gray), 32'(gray(11'd1024)));

    // Rejected push while full
    applyStimulus(1'b1, 18'h3FFFF);
    checkOutput("ovf_pulse", 32'(overflow), 1);
    checkOutput("ovf_we", 32'(we), 0);
    checkOutput("ovf_count", 32'(wr_count), 1024);
    checkOutput("ovf_wptr", 32'(wr_ptr_gray), 32'(gray(11'd1024)));
    applyStimulus(1'b0, '0);
    checkOutput("ovf_one_cycle", 32'(overflow), 0);
    checkOutput("ovf_full_hold", 32'(full), 1);

    // One slot freed by the read side: visible exactly 3 edges later
    rd_ptr_gray = gray(11'd1);
    applyStimulus(1'b0, '0);
    checkOutput("rd_lat1_full", 32'(full), 1);
    applyStimulus(1'b0, '0);
    checkOutput("rd_lat2_full", 32'(full), 1);
    checkOutput("rd_lat2_count", 32'(wr_count), 1024);
    applyStimulus(1'b0, '0);
    checkOutput("rd_lat3_full", 32'(full), 0);
    checkOutput("rd_lat3_count", 32'(wr_count), 1023);
    sb.push_back({RAM_WD'(0), 18'h0AAAA});
    applyStimulus(1'b1, 18'h0AAAA);
    checkOutput("refill_we", 32'(we), 1);
    checkOutput("refill_full", 32'(full), 1);

    // Drain to empty by advancing the read pointer to the write pointer
    mwbin = 11'd1025;
    rd_ptr_gray = gray(mwbin);
    repeat (3) applyStimulus(1'b0, '0);
    checkOutput("drain_count", 32'(wr_count), 0);
    checkOutput("drain_full", 32'(full), 0);

    // Stream 3000 pushes with the read pointer following through 2 cycles
    d1 = gray(mwbin);
    d2 = gray(mwbin);
    ptr_wraps  = 0;
    addr_wraps = 0;
    prev_waddr = waddr;
    for (int k = 0; k < 3000; k++) begin
      dat = RAM_WW'($urandom);
      sb.push_back({mwbin[RAM_WD-1:0], dat});
      prevg = wr_ptr_gray;
      applyStimulus(1'b1, dat);
      checkOutput("stream_wptr", 32'(wr_ptr_gray), 32'(gray(mwbin)));
      checkOutput("stream_gray_step", 32'($countones(prevg ^ wr_ptr_gray)), (k == 0) ? 32'd0 : 32'd1);
      checkOutput("stream_full", 32'(full), 0);
      if (prevg == gray(11'd2047) && wr_ptr_gray == '0) ptr_wraps++;
      if (prev_waddr == 10'd1023 && waddr == '0) addr_wraps++;
      prev_waddr = waddr;
      mwbin = mwbin + 11'd1;
      rd_ptr_gray = d2;
      d2 = d1;
      d1 = wr_ptr_gray;
    end
    checkOutput("ptr_wrap_seen", 32'(ptr_wraps), 1);
    checkOutput("addr_wrap_seen", 32'(addr_wraps), 2);

    // Reset while a write is in flight
    sb.push_back({mwbin[RAM_WD-1:0], 18'h2A5A5});
    applyStimulus(1'b1, 18'h2A5A5);
    checkOutput("inflight_we", 32'(we), 1);
    rst_int = 1'b0;
    #1;
    checkOutput("arst_we", 32'(we), 0);
    checkOutput("arst_waddr", 32'(waddr), 0);
    checkOutput("arst_data", 32'(data), 0);
    checkOutput("arst_wptr", 32'(wr_ptr_gray), 0);
    checkOutput("arst_full", 32'(full), 0);
    checkOutput("arst_count", 32'(wr_count), 0);
    checkOutput("arst_ovf", 32'(overflow), 0);
    wr_en = 1'b0;
    rd_ptr_gray = '0;
    repeat (2) applyStimulus(1'b0, '0);
    rst_int = 1'b1;
    sb.push_back({RAM_WD'(0), 18'h01234});
    applyStimulus(1'b1, 18'h01234);
    checkOutput("post_rst_we", 32'(we), 1);
    checkOutput("post_rst_count", 32'(wr_count), 1);
    applyStimulus(1'b0, '0);

    // Fill to 1021 entries, then free two slots to reach 1019
    rst_int = 1'b0;
    applyStimulus(1'b0, '0);
    rst_int = 1'b1;
    for (int i = 0; i < 1021; i++) begin
      sb.push_back({RAM_WD'(i), RAM_WW'(i ^ 5)});
      applyStimulus(1'b1, RAM_WW'(i ^ 5));
      checkOutput("af_count", 32'(wr_count), 32'(i + 1));
`ifdef FIFO_WR_AFULL_EN
      checkOutput("af_rise", 32'(afull), (i + 1 >= 1020) ? 32'd1 : 32'd0);
`endif
    end
    rd_ptr_gray = gray(11'd2);
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    checkOutput("af_lat2_count", 32'(wr_count), 1021);
`ifdef FIFO_WR_AFULL_EN
    checkOutput("af_lat2", 32'(afull), 1);
`endif
    applyStimulus(1'b0, '0);
    checkOutput("af_lat3_count", 32'(wr_count), 1019);
`ifdef FIFO_WR_AFULL_EN
    checkOutput("af_fall", 32'(afull), 0);
`endif

    checkOutput("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
